// File: rtl/flip_applier_pkg.sv
`default_nettype none
// ============================================================================
// Module  : flip_applier_pkg
// Brief   : State type and geometry helpers shared by the flip applier.
// Revision: 1.0
// ============================================================================
package flip_applier_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int calc_n_words(input int w_size, input int word_w);
        return w_size / word_w;
    endfunction

    // A single-word memory still needs a one-bit address port.
    function automatic int calc_addr_w(input int n_words);
        return (n_words > 1) ? $clog2(n_words) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/popcount_word.sv
`default_nettype none
// ============================================================================
// Module  : popcount_word
// Brief   : Combinational population count of one memory word.
// Revision: 1.0
// ============================================================================
module popcount_word #(
    parameter int WORD_W = 64,
    parameter int CNT_W  = $clog2(WORD_W + 1)
) (
    input  logic [WORD_W-1:0] word_in,
    output logic [CNT_W-1:0]  count_out
);

    always_comb begin
        count_out = '0;
        for (int i = 0; i < WORD_W; i++) begin
            count_out = count_out + CNT_W'(word_in[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/flip_applier.sv
`default_nettype none
// ============================================================================
// Module  : flip_applier
// Brief   : Applies a W_SIZE-bit flip mask to the weight BRAM via pipelined
//           read-XOR-write. FLIP_APPLIER_COUNT_EN adds flip_count_out.
// Revision: 1.0
// ============================================================================
module flip_applier
    import flip_applier_pkg::*;
#(
    parameter int  W_SIZE       = 3072,
    parameter int  WORD_W       = 64,
    parameter int  BRAM_LATENCY = 2,
    localparam int N_WORDS      = calc_n_words(W_SIZE, WORD_W),
    localparam int ADDR_W       = calc_addr_w(N_WORDS)
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        flip_valid_in,
    output logic                        flip_ready_out,
    input  logic [W_SIZE-1:0]           flip_weight_in,
    output logic [ADDR_W-1:0]           rd_addr_out,
    output logic                        rd_en_out,
    input  logic [WORD_W-1:0]           rd_data_in,
    output logic [ADDR_W-1:0]           wr_addr_out,
    output logic                        wr_en_out,
    output logic [WORD_W-1:0]           wr_data_out,
    output logic                        busy_out,
`ifdef FLIP_APPLIER_COUNT_EN
    output logic [$clog2(W_SIZE+1)-1:0] flip_count_out,
`endif
    output logic                        done_out
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(N_WORDS - 1);

    state_t                   r_state;
    logic [W_SIZE-1:0]        r_mask;
    logic                     r_ready;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_rd_en;
    logic [ADDR_W-1:0]        r_rd_addr;
    logic [BRAM_LATENCY-1:0]  r_pipe_valid;
    logic [ADDR_W-1:0]        r_pipe_addr [BRAM_LATENCY];

    logic                     w_accept;
    logic                     w_wr_valid;
    logic [ADDR_W-1:0]        w_wr_addr;
    logic [WORD_W-1:0]        w_slice;
    logic                     w_last_write;

    // The last pipeline stage lines up with BRAM dout, so the write is formed
    // straight from it without another register.
    assign w_accept     = flip_valid_in & r_ready;
    assign w_wr_valid   = r_pipe_valid[BRAM_LATENCY-1];
    assign w_wr_addr    = r_pipe_addr[BRAM_LATENCY-1];
    assign w_slice      = r_mask[int'(w_wr_addr)*WORD_W +: WORD_W];
    assign w_last_write = w_wr_valid && (w_wr_addr == c_last_addr);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= IDLE;
            r_mask       <= '0;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_rd_en      <= 1'b0;
            r_rd_addr    <= '0;
            r_pipe_valid <= '0;
            for (int i = 0; i < BRAM_LATENCY; i++) begin
                r_pipe_addr[i] <= '0;
            end
        end else begin
            r_pipe_valid[0] <= r_rd_en;
            r_pipe_addr[0]  <= r_rd_addr;
            for (int i = 1; i < BRAM_LATENCY; i++) begin
                r_pipe_valid[i] <= r_pipe_valid[i-1];
                r_pipe_addr[i]  <= r_pipe_addr[i-1];
            end
            r_done <= 1'b0;

            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_mask <= flip_weight_in;
                        if (|flip_weight_in) begin
                            r_state   <= RUN;
                            r_ready   <= 1'b0;
                            r_busy    <= 1'b1;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= '0;
                        end else begin
                            // Nothing to flip: finish without touching memory.
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    if (r_rd_addr == c_last_addr) begin
                        r_state   <= DRAIN;
                        r_rd_en   <= 1'b0;
                        r_rd_addr <= '0;
                    end else begin
                        r_rd_addr <= r_rd_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (w_last_write) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign flip_ready_out = r_ready;
    assign busy_out       = r_busy;
    assign done_out       = r_done;
    assign rd_en_out      = r_rd_en;
    assign rd_addr_out    = r_rd_addr;
    assign wr_en_out      = w_wr_valid;
    assign wr_addr_out    = w_wr_addr;
    assign wr_data_out    = w_wr_valid ? (rd_data_in ^ w_slice) : '0;

`ifdef FLIP_APPLIER_COUNT_EN
    localparam int CNT_W = $clog2(W_SIZE + 1);
    localparam int POP_W = $clog2(WORD_W + 1);

    logic [POP_W-1:0] w_pop;
    logic [CNT_W-1:0] r_count;

    popcount_word #(
        .WORD_W (WORD_W),
        .CNT_W  (POP_W)
    ) u_popcount (
        .word_in   (w_slice),
        .count_out (w_pop)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in || w_accept) begin
            r_count <= '0;
        end else if (w_wr_valid) begin
            r_count <= r_count + CNT_W'(w_pop);
        end
    end

    assign flip_count_out = r_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_flip_applier.sv
`default_nettype none
// ============================================================================
// Module  : tb_flip_applier
// Brief   : Directed and random checks of flip_applier against a BRAM model
//           and a word-level XOR scoreboard. Revision: 1.0
// ============================================================================
module tb_flip_applier;

    localparam int W_SIZE  = 256;
    localparam int WORD_W  = 64;
    localparam int LAT     = 2;
    localparam int N_WORDS = W_SIZE / WORD_W;
    localparam int ADDR_W  = 2;
    localparam int T_DONE  = N_WORDS + LAT + 1;

    logic              clk = 1'b0;
    logic              rst_in;
    logic              flip_valid_in;
    logic              flip_ready_out;
    logic [W_SIZE-1:0] flip_weight_in;
    logic [ADDR_W-1:0] rd_addr_out;
    logic              rd_en_out;
    logic [WORD_W-1:0] rd_data_in = '0;
    logic [ADDR_W-1:0] wr_addr_out;
    logic              wr_en_out;
    logic [WORD_W-1:0] wr_data_out;
    logic              busy_out;
    logic              done_out;
`ifdef FLIP_APPLIER_COUNT_EN
    logic [$clog2(W_SIZE+1)-1:0] flip_count;
`endif

    always #5 clk = ~clk;

    flip_applier #(
        .W_SIZE       (W_SIZE),
        .WORD_W       (WORD_W),
        .BRAM_LATENCY (LAT)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .flip_valid_in  (flip_valid_in),
        .flip_ready_out (flip_ready_out),
        .flip_weight_in (flip_weight_in),
        .rd_addr_out    (rd_addr_out),
        .rd_en_out      (rd_en_out),
        .rd_data_in     (rd_data_in),
        .wr_addr_out    (wr_addr_out),
        .wr_en_out      (wr_en_out),
        .wr_data_out    (wr_data_out),
        .busy_out       (busy_out),
`ifdef FLIP_APPLIER_COUNT_EN
        .flip_count_out (flip_count),
`endif
        .done_out       (done_out)
    );

    // Behavioural dual-port BRAM with two-cycle read latency.
    logic [WORD_W-1:0] mem [N_WORDS];
    logic [WORD_W-1:0] load_val [N_WORDS];
    logic              load_req = 1'b0;
    logic [WORD_W-1:0] rd_stage = '0;

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < N_WORDS; i++) mem[i] <= load_val[i];
        end else if (wr_en_out) begin
            mem[wr_addr_out] <= wr_data_out;
        end
        rd_stage   <= rd_en_out ? mem[rd_addr_out] : '0;
        rd_data_in <= rd_stage;
    end

    logic [WORD_W-1:0] ref_mem [N_WORDS];
    int cyc = 0, acc = 0;
    int nwr, nrd, ndone, first_wr, last_wr, done_rel;
    int n_checks = 0, n_pass = 0;

    function automatic logic [W_SIZE-1:0] mem_flat();
        for (int i = 0; i < N_WORDS; i++) mem_flat[i*WORD_W +: WORD_W] = mem[i];
    endfunction

    function automatic logic [W_SIZE-1:0] ref_flat();
        for (int i = 0; i < N_WORDS; i++) ref_flat[i*WORD_W +: WORD_W] = ref_mem[i];
    endfunction

    task automatic check(input string tag, input logic [W_SIZE-1:0] obs,
                         input logic [W_SIZE-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (wr_en_out) begin
            nwr++;
            if (first_wr < 0) first_wr = cyc - acc;
            last_wr = cyc - acc;
        end
        if (rd_en_out) nrd++;
        if (done_out) ndone++;
    endtask

    task automatic clear_stats();
        nwr = 0; nrd = 0; ndone = 0; first_wr = -1; last_wr = -1;
    endtask

    // Scoreboard: every word is XORed with its mask slice.
    task automatic apply_ref(input logic [W_SIZE-1:0] m);
        for (int i = 0; i < N_WORDS; i++) ref_mem[i] ^= m[i*WORD_W +: WORD_W];
    endtask

    task automatic load_mem(input logic [WORD_W-1:0] seed);
        for (int i = 0; i < N_WORDS; i++) begin
            load_val[i] = seed ^ (64'h0123_4567_89AB_CDEF * (i + 1));
            ref_mem[i]  = load_val[i];
        end
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    // Presents the mask and returns on the accepting cycle (cycle 0).
    task automatic begin_op(input logic [W_SIZE-1:0] m);
        flip_weight_in = m;
        flip_valid_in  = 1'b1;
        for (int k = 0; k < 50 && !flip_ready_out; k++) tick();
        acc = cyc;
        clear_stats();
    endtask

    task automatic finish_op(input bit hold);
        done_rel = -1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (!hold) flip_valid_in = 1'b0;
            if (done_out) begin
                done_rel = cyc - acc;
                break;
            end
        end
    endtask

    task automatic check_count(input string tag, input logic [W_SIZE-1:0] m);
`ifdef FLIP_APPLIER_COUNT_EN
        check(tag, W_SIZE'(flip_count), W_SIZE'($countones(m)));
`else
        if (m === 'x) check(tag, '0, '1);
`endif
    endtask

    logic [W_SIZE-1:0] m, m2;
    logic [W_SIZE-1:0] ones = '1;

    initial begin
        rst_in = 1'b1; flip_valid_in = 1'b0; flip_weight_in = '0;
        tick(); tick();
        check("reset_ready", W_SIZE'(flip_ready_out), 1);
        check("reset_ctrl", W_SIZE'({busy_out, done_out, rd_en_out, wr_en_out}), 0);
        check("reset_bus", W_SIZE'({rd_addr_out, wr_addr_out, wr_data_out}), 0);
        rst_in = 1'b0;
        tick();

        // Single-bit flips at both ends of the weight vector.
        load_mem('0);
        for (int i = 0; i < N_WORDS; i++) begin
            load_val[i] = '0; ref_mem[i] = '0;
        end
        load_req = 1'b1; tick(); load_req = 1'b0;
        m = '0; m[0] = 1'b1; m[255] = 1'b1;
        begin_op(m);
        finish_op(0);
        apply_ref(m);
        check("t1_done_cycle", W_SIZE'(done_rel), W_SIZE'(T_DONE));
        check("t1_first_write", W_SIZE'(first_wr), 3);
        check("t1_last_write", W_SIZE'(last_wr), 6);
        check("t1_reads", W_SIZE'(nrd), W_SIZE'(N_WORDS));
        check("t1_mem", mem_flat(), {64'h8000_0000_0000_0000, 64'h0, 64'h0, 64'h1});
        check_count("t1_count", m);
        tick();
        check("t1_done_pulse", W_SIZE'({done_out, flip_ready_out, busy_out}), 3'b010);

        // All-zero mask: no memory traffic, done on cycle 1.
        begin_op('0);
        finish_op(0);
        check("t2_done_cycle", W_SIZE'(done_rel), 1);
        check("t2_traffic", W_SIZE'({nrd, nwr}), 0);
        check("t2_mem", mem_flat(), ref_flat());
        check_count("t2_count", '0);

        // Two all-ones masks back to back restore the original pattern.
        load_mem(64'hA5A5_0000_FFFF_1234);
        begin_op(ones);
        finish_op(1);
        check("t3_first_done", W_SIZE'(done_rel), W_SIZE'(T_DONE));
        check("t3_ready_in_done", W_SIZE'(flip_ready_out), 1);
        check_count("t3_count1", ones);
        acc = cyc;
        clear_stats();
        finish_op(0);
        check("t3_second_done", W_SIZE'(done_rel), W_SIZE'(T_DONE));
        check("t3_mem_restored", mem_flat(), ref_flat());
        check_count("t3_count2", ones);

        // Reset in cycle 4 leaves only words 0 and 1 inverted.
        begin_op(ones);
        tick(); flip_valid_in = 1'b0;
        tick(); tick(); tick();
        rst_in = 1'b1;
        tick();
        check("t4_after_reset", W_SIZE'({wr_en_out, rd_en_out, flip_ready_out, busy_out}), 4'b0010);
        rst_in = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("t4_no_done", W_SIZE'(ndone), 0);
        ref_mem[0] = ~ref_mem[0]; ref_mem[1] = ~ref_mem[1];
        check("t4_mem", mem_flat(), ref_flat());

        // A second mask offered while busy is ignored.
        for (int i = 0; i < 8; i++) begin
            m[i*32 +: 32] = $urandom; m2[i*32 +: 32] = $urandom;
        end
        begin_op(m);
        tick(); flip_valid_in = 1'b0;
        tick(); tick();
        flip_valid_in = 1'b1; flip_weight_in = m2;
        tick(); flip_valid_in = 1'b0;
        finish_op(0);
        apply_ref(m);
        check("t5_done_cycle", W_SIZE'(done_rel), W_SIZE'(T_DONE));
        for (int k = 0; k < 4; k++) tick();
        check("t5_single_run", W_SIZE'({nrd, ndone}), W_SIZE'({N_WORDS, 1}));
        check("t5_mem", mem_flat(), ref_flat());

        // Random masks, some sparse, against the scoreboard.
        for (int r = 0; r < 100; r++) begin
            for (int i = 0; i < 8; i++) begin
                m[i*32 +: 32] = $urandom;
                if (r % 3 == 1) m[i*32 +: 32] &= $urandom;
            end
            begin_op(m);
            finish_op(0);
            apply_ref(m);
            check("rnd_done_cycle", W_SIZE'(done_rel), W_SIZE'(T_DONE));
            check("rnd_mem", mem_flat(), ref_flat());
            check_count("rnd_count", m);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/flip_applier.md
Name: flip_applier

Overview:
- Consumer of the masked per-weight flip vector produced by the stochastic gradient stage.
- Accepts one W_SIZE-bit flip mask via a valid/ready handshake.
- Walks the binary weight memory word by word and performs a pipelined read-modify-write: new_word = old_word XOR mask slice.
- Sits between the gradient path and the dual-port weight BRAM; pulses done when the whole memory has been updated.

Parameters:
- W_SIZE, 3072, total number of binary weights; must be a multiple of WORD_W.
- WORD_W, 64, BRAM data width in bits.
- BRAM_LATENCY, 2, read latency in cycles (address to dout valid); must be ≥1.
- Derived (localparam): N_WORDS = W_SIZE/WORD_W; ADDR_W = $clog2(N_WORDS).

Ports:
- clk_in  input  1  single clock.
- rst_in  input  1  synchronous, active-high reset.
- flip_valid_in  input  1  mask valid.
- flip_ready_out  output  1  block idle, can accept a mask.
- flip_weight_in  input  W_SIZE  bit i = 1 means flip weight i.
- rd_addr_out  output  ADDR_W  BRAM port A read address.
- rd_en_out  output  1  BRAM port A read enable.
- rd_data_in  input  WORD_W  BRAM port A dout.
- wr_addr_out  output  ADDR_W  BRAM port B write address.
- wr_en_out  output  1  BRAM port B write enable.
- wr_data_out  output  WORD_W  BRAM port B din.
- busy_out  output  1  update in progress.
- done_out  output  1  one-cycle pulse when the update is complete.

Behaviour:
- Reset: state IDLE; flip_ready_out=1; busy_out=0; done_out=0; rd_en_out=0; wr_en_out=0; all addresses and wr_data_out = 0; pipeline valid bits cleared.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: on flip_valid_in & flip_ready_out (cycle 0), latch the mask and go to RUN; ready drops at cycle 1.
  - If the latched mask is all zero, go to DONE instead. No BRAM traffic occurs.
- RUN: from cycle 1, issue rd_en_out=1 with rd_addr_out = 0,1,…,N_WORDS-1 on consecutive cycles. After the last address, go to DRAIN.
- Pipeline: a BRAM_LATENCY-deep shift register carries (valid, addr). Data read at cycle c is used at cycle c+BRAM_LATENCY.
  - At that cycle: wr_en_out=1, wr_addr_out = addr, wr_data_out = rd_data_in ^ mask[addr*WORD_W +: WORD_W].
  - Write outputs are combinational from rd_data_in and the pipeline stage.
  - Writes carry no extra register stage.
  - Words with a zero mask slice are still written; the written value equals the read value.
- Read and write addresses are always distinct (read leads write by BRAM_LATENCY), so there is no RAW hazard.
- DRAIN: wait until the pipeline is empty, then go to DONE. The last write occurs at cycle N_WORDS+BRAM_LATENCY.
- DONE: done_out=1 for exactly one cycle (cycle N_WORDS+BRAM_LATENCY+1, or cycle 1 for an all-zero mask). flip_ready_out=1 in the same cycle, and a new mask may be accepted that cycle. Then return to IDLE.
- busy_out=1 in RUN and DRAIN only.
- flip_valid_in while not ready: ignored; flip_weight_in is not sampled.
- Reset mid-operation: on the cycle after rst_in, wr_en_out=0 and rd_en_out=0. Words already written stay updated; no rollback. The pending mask is discarded.

Optional Feature:
- Macro: FLIP_APPLIER_COUNT_EN.
- With the macro defined: extra output flip_count_out, width $clog2(W_SIZE+1).
  - Holds the popcount of the accepted mask, accumulated per word on each write.
  - Valid when done_out is high; held until the next accept; cleared to 0 on reset and on accept.
  - All-zero mask gives 0.
- Without the macro: the port and the counting logic are absent; all other behaviour is identical.

Decomposition:
- Package flip_applier_pkg: state enum type (IDLE, RUN, DRAIN, DONE) and a function computing N_WORDS/ADDR_W from the parameters.
- Sub-module popcount_word (WORD_W-bit combinational popcount), instantiated only under FLIP_APPLIER_COUNT_EN.

Test Plan (W_SIZE=256, WORD_W=64, BRAM_LATENCY=2, behavioural BRAM model):
- Memory all 0; mask bits 0 and 255 set:
  - word0=64'h1, word3=64'h8000_0000_0000_0000, words 1–2 = 0.
  - Writes occur in cycles 3–6; done_out pulses in cycle 7 only.
- All-zero mask: wr_en_out and rd_en_out never assert; done_out in cycle 1; memory unchanged; count = 0.
- Memory preset to a known pattern; all-ones mask applied twice back-to-back (valid held high):
  - Second mask accepted in the done cycle of the first.
  - Memory equals the original pattern after the second done.
  - count = 256 each time.
- rst_in asserted in cycle 4 of a run with mask = all ones:
  - Next cycle: wr_en_out=0, flip_ready_out=1.
  - Only word0 and word1 inverted; no done_out.
- flip_valid_in pulsed with a different mask during busy: ignored; memory reflects only the first mask.
- Random masks ×100 against a scoreboard XOR model: memory matches the model; done timing is always N_WORDS+BRAM_LATENCY+1 cycles after accept.
